// File: rtl/adc_spi_frontend.sv
// adc_spi_frontend: acquisition front end for an 8-channel simultaneous-sampling
// parallel-bus SAR ADC, with a slave SPI port that offers the latest frame to a host.
// Optional feature macro: FRAME_COUNTER_EN prepends a 16-bit frame counter to each
// SPI frame (frame length becomes (NUM_CH+1)*16 bits).
`timescale 1ns/1ps

module adc_spi_frontend #(
    parameter int NUM_CH       = 8,
    parameter int SAMPLE_DIV   = 500,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic        CLOCK_27M,
    input  logic        rst,
    input  logic        KEY2,
    input  logic [15:0] DB,
    input  logic        Busy,
    input  logic        sclk,
    input  logic        SPI_cs,
    input  logic        transaction_done,
    output logic        convst_A,
    output logic        convst_B,
    output logic        convst_C,
    output logic        convst_D,
    output logic        RD_N,
    output logic        ADC_CS_N,
    output logic        HW_N,
    output logic        PAR_N,
    output logic        STBY_N,
    output logic        WR_N,
    output logic        ADCrst,
    output logic        XCLK,
    output logic        processed_MISO,
    output logic        SPI_RDY
);

    localparam int WORD_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
    localparam int CYC_W  = $clog2(BUSY_TIMEOUT + 1) + 1;
    localparam int DATA_W = NUM_CH * 16;
`ifdef FRAME_COUNTER_EN
    localparam int FRAME_W = DATA_W + 16;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int BIT_W  = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT_BH,
        ST_WAIT_BL,
        ST_READ,
        ST_DONE
    } state_e;

    // Channel 0 lands in the most significant word so it is shifted out first.
    function automatic logic [DATA_W-1:0] pack_words(input logic [NUM_CH-1:0][15:0] words);
        logic [DATA_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            f[DATA_W-1-16*i -: 16] = words[i];
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Reset sequencing, XCLK and input synchronizers
    // ------------------------------------------------------------------
    logic [2:0] rst_cnt_q;
    logic       adcrst_q;
    logic       xclk_q;
    logic [2:0] busy_sync_q;
    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;

    // Hold the ADC in reset for four cycles after rst is released
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            rst_cnt_q <= 3'd0;
            adcrst_q  <= 1'b1;
        end else if (rst_cnt_q != 3'd4) begin
            rst_cnt_q <= rst_cnt_q + 3'd1;
            adcrst_q  <= (rst_cnt_q < 3'd3);
        end else begin
            rst_cnt_q <= rst_cnt_q;
            adcrst_q  <= 1'b0;
        end
    end

    // XCLK runs at half the system clock
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            xclk_q <= 1'b0;
        end else begin
            xclk_q <= ~xclk_q;
        end
    end

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            busy_sync_q <= 3'b000;
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
        end else begin
            busy_sync_q <= {busy_sync_q[1:0], Busy};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], SPI_cs};
        end
    end

    logic busy_rise_s, busy_fall_s, sclk_fall_s, cs_fall_s, cs_high_s;
    assign busy_rise_s = busy_sync_q[1] & ~busy_sync_q[2];
    assign busy_fall_s = ~busy_sync_q[1] & busy_sync_q[2];
    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_high_s   = cs_sync_q[1];

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick_s;

    assign tick_s = ~adcrst_q & (div_q == DIV_W'(SAMPLE_DIV - 1));

    // Free-running divider that starts once the ADC leaves reset
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (adcrst_q || tick_s) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Acquisition FSM
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              convst_q, convst_d;
    logic              rd_n_q, rd_n_d;
    logic              adc_cs_n_q, adc_cs_n_d;
    logic              latch_s;
    logic              done_s;

    // FSM state and registered ADC control outputs
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            word_q     <= '0;
            convst_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            adc_cs_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            word_q     <= word_d;
            convst_q   <= convst_d;
            rd_n_q     <= rd_n_d;
            adc_cs_n_q <= adc_cs_n_d;
        end
    end

    // Next-state logic: convert, wait BUSY high then low, then burst-read NUM_CH words
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        word_d     = word_q;
        convst_d   = convst_q;
        rd_n_d     = rd_n_q;
        adc_cs_n_d = adc_cs_n_q;
        latch_s    = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s && !KEY2) begin
                    state_d  = ST_CONV;
                    cyc_d    = '0;
                    convst_d = 1'b0;
                end else begin
                    convst_d = 1'b1;
                end
            end
            ST_CONV: begin
                if (cyc_q == CYC_W'(1)) begin
                    state_d  = ST_WAIT_BH;
                    cyc_d    = '0;
                    convst_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_WAIT_BH: begin
                if (busy_rise_s) begin
                    state_d = ST_WAIT_BL;
                    cyc_d   = '0;
                end else if (cyc_q == CYC_W'(BUSY_TIMEOUT)) begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_WAIT_BL: begin
                if (busy_fall_s) begin
                    state_d    = ST_READ;
                    cyc_d      = '0;
                    word_d     = '0;
                    adc_cs_n_d = 1'b0;
                    rd_n_d     = 1'b0;
                end else if (cyc_q == CYC_W'(BUSY_TIMEOUT)) begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_READ: begin
                // Per word: two cycles RD_N low (latch on the second), two cycles high
                case (cyc_q[1:0])
                    2'd1: begin
                        latch_s = 1'b1;
                        rd_n_d  = 1'b1;
                        cyc_d   = cyc_q + CYC_W'(1);
                    end
                    2'd3: begin
                        if (word_q == WORD_W'(NUM_CH - 1)) begin
                            state_d    = ST_DONE;
                            adc_cs_n_d = 1'b1;
                            cyc_d      = '0;
                        end else begin
                            word_d = word_q + WORD_W'(1);
                            rd_n_d = 1'b0;
                            cyc_d  = '0;
                        end
                    end
                    default: begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                endcase
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                convst_d   = 1'b1;
                rd_n_d     = 1'b1;
                adc_cs_n_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture buffer and hand-off to the SPI buffer
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][15:0] cap_q;
    logic [NUM_CH-1:0][15:0] spi_buf_q;
    logic                    pend_q;
    logic                    copied_q;
    logic                    copy_s;

    // Copy only while the host is deselected and the capture buffer is not being rewritten
    assign copy_s = pend_q & cs_high_s & (state_q != ST_READ);

    // Latch each ADC word on the last low cycle of its RD_N strobe
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            cap_q <= '0;
        end else if (latch_s) begin
            cap_q[word_q] <= DB;
        end else begin
            cap_q <= cap_q;
        end
    end

    // Completed capture waits here until SPI_cs is high, then copies (latest frame wins)
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            pend_q    <= 1'b0;
            copied_q  <= 1'b0;
            spi_buf_q <= '0;
        end else begin
            copied_q <= copy_s;
            if (done_s) begin
                pend_q <= 1'b1;
            end else if (copy_s) begin
                pend_q <= 1'b0;
            end else begin
                pend_q <= pend_q;
            end
            if (copy_s) begin
                spi_buf_q <= cap_q;
            end else begin
                spi_buf_q <= spi_buf_q;
            end
        end
    end

`ifdef FRAME_COUNTER_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] spi_cnt_q;

    // Count completed captures and snapshot the count alongside each copy
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 16'd0;
            spi_cnt_q   <= 16'd0;
        end else begin
            if (done_s) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
                frame_cnt_q <= frame_cnt_q;
            end
            if (copy_s) begin
                spi_cnt_q <= frame_cnt_q;
            end else begin
                spi_cnt_q <= spi_cnt_q;
            end
        end
    end

    logic [FRAME_W-1:0] load_frame_s;
    assign load_frame_s = {spi_cnt_q, pack_words(spi_buf_q)};
`else
    logic [FRAME_W-1:0] load_frame_s;
    assign load_frame_s = pack_words(spi_buf_q);
`endif

    // ------------------------------------------------------------------
    // SPI slave (mode 0)
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               miso_q, miso_d;
    logic               rdy_q, rdy_d;

    // Shift register, bit counter, MISO and SPI_RDY registers
    always_ff @(posedge CLOCK_27M or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            miso_q    <= miso_d;
            rdy_q     <= rdy_d;
        end
    end

    // Load on SPI_cs fall, shift on sclk fall, zero past the end or on transaction_done
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (transaction_done) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (cs_fall_s) begin
            shreg_d   = load_frame_s;
            bit_cnt_d = '0;
        end else if (sclk_fall_s && !cs_high_s) begin
            if (bit_cnt_q < BIT_W'(FRAME_W)) begin
                shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else begin
                shreg_d   = '0;
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            shreg_d   = shreg_q;
            bit_cnt_d = bit_cnt_q;
        end

        miso_d = ~cs_high_s & shreg_d[FRAME_W-1];

        if (transaction_done || cs_fall_s) begin
            rdy_d = 1'b0;
        end else if (copied_q) begin
            rdy_d = 1'b1;
        end else begin
            rdy_d = rdy_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign convst_A       = convst_q;
    assign convst_B       = convst_q;
    assign convst_C       = convst_q;
    assign convst_D       = convst_q;
    assign RD_N           = rd_n_q;
    assign ADC_CS_N       = adc_cs_n_q;
    assign HW_N           = 1'b0;
    assign PAR_N          = 1'b0;
    assign STBY_N         = 1'b1;
    assign WR_N           = 1'b1;
    assign ADCrst         = adcrst_q;
    assign XCLK           = xclk_q;
    assign processed_MISO = miso_q;
    assign SPI_RDY        = rdy_q;

endmodule

// File: tb/tb_adc_spi_frontend.sv
// Self-checking bench for adc_spi_frontend: behavioural ADC model, SPI host,
// and a scoreboard monitor that compares each received 16-bit SPI word.
`timescale 1ns/1ps

module tb_adc_spi_frontend;

    logic        clk;
    logic        rst;
    logic        KEY2;
    logic [15:0] DB;
    logic        Busy;
    logic        sclk;
    logic        SPI_cs;
    logic        transaction_done;
    logic        convst_A, convst_B, convst_C, convst_D;
    logic        RD_N, ADC_CS_N, HW_N, PAR_N, STBY_N, WR_N;
    logic        ADCrst, XCLK, processed_MISO, SPI_RDY;

    adc_spi_frontend dut (
        .CLOCK_27M        (clk),
        .rst              (rst),
        .KEY2             (KEY2),
        .DB               (DB),
        .Busy             (Busy),
        .sclk             (sclk),
        .SPI_cs           (SPI_cs),
        .transaction_done (transaction_done),
        .convst_A         (convst_A),
        .convst_B         (convst_B),
        .convst_C         (convst_C),
        .convst_D         (convst_D),
        .RD_N             (RD_N),
        .ADC_CS_N         (ADC_CS_N),
        .HW_N             (HW_N),
        .PAR_N            (PAR_N),
        .STBY_N           (STBY_N),
        .WR_N             (WR_N),
        .ADCrst           (ADCrst),
        .XCLK             (XCLK),
        .processed_MISO   (processed_MISO),
        .SPI_RDY          (SPI_RDY)
    );

    // 40 ns system clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    // ADC model state
    bit          armed = 1'b0;
    bit          busy_en = 1'b0;
    logic [15:0] adc_base = 16'h1000;
    int          convst_cnt = 0;
    int          rd_cnt = 0;
    logic [2:0]  rd_idx = 3'd0;

    assign DB = adc_base + {13'd0, rd_idx};

    // Count conversion starts
    always @(negedge convst_A) begin
        if (armed) convst_cnt++;
    end

    // BUSY pulse of 1 us after each conversion start
    always @(posedge convst_A) begin
        if (armed && busy_en) begin
            #20 Busy = 1'b1;
            #1000 Busy = 1'b0;
        end
    end

    // Advance the channel index at the end of each RD_N strobe
    always @(posedge RD_N) begin
        if (armed) begin
            rd_cnt++;
            rd_idx = rd_idx + 3'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: assemble words on sclk rising edges and compare against the queue
    initial begin : monitor
        int          mon_n;
        logic [15:0] mon_sh;
        logic [15:0] exp_w;
        mon_n  = 0;
        mon_sh = 16'h0000;
        forever begin
            @(posedge sclk or posedge SPI_cs);
            if (SPI_cs) begin
                mon_n = 0;
            end else begin
                mon_sh = {mon_sh[14:0], processed_MISO};
                mon_n++;
                if (mon_n == 16) begin
                    mon_n = 0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL spi_word: got %h, expected nothing queued", mon_sh);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (mon_sh !== exp_w) begin
                            n_err++;
                            $display("FAIL spi_word: got %h, expected %h", mon_sh, exp_w);
                        end
                    end
                end
            end
        end
    end

    task automatic spi_begin();
        SPI_cs = 1'b0;
        #250;
    endtask

    task automatic spi_clock(input int nbits);
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b1;
            #250;
            sclk = 1'b0;
            #250;
        end
    endtask

    task automatic spi_end();
        SPI_cs = 1'b1;
        #250;
    endtask

    task automatic push_frame(input logic [15:0] base);
        for (int i = 0; i < 8; i++) exp_q.push_back(base + 16'(i));
    endtask

    task automatic wait_rdy(input int budget, input string name);
        int k;
        k = 0;
        while (SPI_RDY !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, SPI_RDY}, 32'd1);
    endtask

    task automatic wait_convst(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (convst_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, convst_cnt, target);
    endtask

    task automatic pulse_td();
        @(negedge clk);
        transaction_done = 1'b1;
        @(negedge clk);
        transaction_done = 1'b0;
    endtask

    // Global time bound
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic x0;
        int   c0;
        int   r0;
        rst = 1'b1;
        KEY2 = 1'b1;
        sclk = 1'b0;
        SPI_cs = 1'b1;
        transaction_done = 1'b0;
        Busy = 1'b0;

        // Reset values and constant pins
        #5 rst = 1'b0;
        #45;
        check("reset_outputs",
              {18'd0, convst_A, convst_B, convst_C, convst_D, RD_N, ADC_CS_N, ADCrst,
               XCLK, processed_MISO, SPI_RDY, HW_N, PAR_N, STBY_N, WR_N},
              {18'd0, 14'b1111111_00000_11});
        #60 rst = 1'b1;
        armed = 1'b1;
        busy_en = 1'b1;

        // ADCrst held four cycles after release
        repeat (3) @(posedge clk);
        #1 check("adcrst_hold", {31'd0, ADCrst}, 32'd1);
        @(posedge clk);
        #1 check("adcrst_release", {31'd0, ADCrst}, 32'd0);
        x0 = XCLK;
        @(posedge clk);
        #1 check("xclk_toggle", {31'd0, XCLK}, {31'd0, ~x0});

        // First frame: 0x1000 + ch
        KEY2 = 1'b0;
        wait_rdy(1500, "first_frame_rdy");
        KEY2 = 1'b1;
        check("convst_pulses", convst_cnt, 1);
        check("rd_pulses", rd_cnt, 8);

        // Read it, clocking one word past the end (zeros)
        push_frame(16'h1000);
        exp_q.push_back(16'h0000);
        spi_begin();
        check("rdy_clear_on_cs", {31'd0, SPI_RDY}, 32'd0);
        spi_clock(144);
        spi_end();
        repeat (10) @(negedge clk);
        check("miso_idle", {31'd0, processed_MISO}, 32'd0);
        check("rdy_stays_low_paused", {31'd0, SPI_RDY}, 32'd0);
        check("key2_pause", convst_cnt, 1);
        check("queue_drained_1", exp_q.size(), 0);

        // BUSY never rises: timeout, no read, then a retry on the next tick
        busy_en = 1'b0;
        c0 = convst_cnt;
        r0 = rd_cnt;
        KEY2 = 1'b0;
        wait_convst(c0 + 1, 700, "timeout_conv_start");
        repeat (300) @(negedge clk);
        check("timeout_no_read", rd_cnt, r0);
        check("timeout_cs_idle", {31'd0, ADC_CS_N}, 32'd1);
        check("timeout_no_rdy", {31'd0, SPI_RDY}, 32'd0);
        busy_en = 1'b1;
        adc_base = 16'h2000;
        wait_convst(c0 + 2, 700, "timeout_retry");
        wait_rdy(300, "retry_frame_rdy");
        KEY2 = 1'b1;
        check("retry_rd_pulses", rd_cnt, r0 + 8);

        // Captures complete while SPI_cs is low: old frame kept, new one after cs rises
        push_frame(16'h2000);
        spi_begin();
        c0 = convst_cnt;
        adc_base = 16'h4000;
        KEY2 = 1'b0;
        spi_clock(128);
        check("captures_during_read", (convst_cnt >= c0 + 2) ? 32'd1 : 32'd0, 32'd1);
        check("rdy_deferred", {31'd0, SPI_RDY}, 32'd0);
        spi_end();
        wait_rdy(200, "rdy_after_cs_rise");
        KEY2 = 1'b1;
        repeat (100) @(negedge clk);

        // transaction_done with cs high clears SPI_RDY
        check("rdy_before_td", {31'd0, SPI_RDY}, 32'd1);
        pulse_td();
        @(negedge clk);
        check("td_clears_rdy", {31'd0, SPI_RDY}, 32'd0);

        // transaction_done mid-read zeroes the rest of the stream
        exp_q.push_back(16'h4000);
        exp_q.push_back(16'h4000);
        spi_begin();
        spi_clock(20);
        pulse_td();
        repeat (2) @(negedge clk);
        check("td_miso_zero", {31'd0, processed_MISO}, 32'd0);
        check("td_rdy_zero", {31'd0, SPI_RDY}, 32'd0);
        spi_clock(12);
        spi_end();

        // Full read of the newest frame
        push_frame(16'h4000);
        spi_begin();
        spi_clock(128);
        spi_end();
        repeat (10) @(negedge clk);
        check("queue_drained_2", exp_q.size(), 0);
        check("miso_idle_end", {31'd0, processed_MISO}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
